// File: rtl/mcpu_uart_tx.sv
// mcpu_uart_tx: memory-mapped UART transmitter with an 8-entry (parameterisable)
// transmit FIFO on a shared tri-state CPU data bus.
//   addr 0 write : push data_bus[7:0]
//   addr 1 read  : STATUS {count[7:4], overrun, active, empty, full}
//   addr 2 write : CTRL  (bit0 enable)
// Optional build macro MCPU_UART_TX_PARITY_EN adds an even-parity bit (8E1).
module mcpu_uart_tx #(
   parameter int DATA_WIDTH   = 16,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            io_addr,
   input  logic                  io_we,
   input  logic                  io_re,
   inout  wire  [DATA_WIDTH-1:0] data_bus,
   output logic                  txd,
   output logic                  tx_busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int KW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [KW-1:0] KMAX    = KW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef MCPU_UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_e;

   state_e          state_q, state_d;
   logic [KW-1:0]   clk_cnt_q, clk_cnt_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            txd_q, txd_d;
   logic            active_q;
   logic            enable_q, enable_d;
   logic            overrun_q, overrun_d;
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef MCPU_UART_TX_PARITY_EN
   logic            parity_q, parity_d;
`endif

   logic            push_req, push_ok, ctrl_wr, status_rd;
   logic            fifo_nempty, bit_end, start_ok, pop;
   logic            frame_active;
   logic [7:0]      head;
   logic [31:0]     cnt32;
   logic [DATA_WIDTH-1:0] status_w;
   logic            unused_bus;

   // Bus decode; a write strobe always wins over a concurrent read
   assign push_req    = io_we && (io_addr == 2'd0);
   assign ctrl_wr     = io_we && (io_addr == 2'd2);
   assign status_rd   = io_re && !io_we && (io_addr == 2'd1);
   assign push_ok     = push_req && (count_q < DEPTH_C);
   assign fifo_nempty = (count_q != '0);
   assign bit_end     = (clk_cnt_q == KMAX);
   assign start_ok    = enable_q && fifo_nempty;
   assign head        = mem_q[rptr_q];
   assign unused_bus  = ^data_bus[DATA_WIDTH-1:8];

   // active_q follows the state by one cycle so it lines up with registered txd
   assign frame_active = (state_q != S_IDLE) || active_q;
   assign tx_busy      = fifo_nempty || frame_active;
   assign txd          = txd_q;

   // Frame sequencer: next state, bit timing, shift register and FIFO pop
   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      pop       = 1'b0;
`ifdef MCPU_UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      if (state_q != S_IDLE) clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
      case (state_q)
         S_IDLE: if (start_ok) begin
            pop       = 1'b1;
            state_d   = S_START;
            clk_cnt_d = '0;
            shift_d   = head;
`ifdef MCPU_UART_TX_PARITY_EN
            parity_d  = ^head;
`endif
         end
         S_START: if (bit_end) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
         end
         S_DATA: if (bit_end) begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef MCPU_UART_TX_PARITY_EN
            if (bit_cnt_q == 3'd7) state_d = S_PARITY;
`else
            if (bit_cnt_q == 3'd7) state_d = S_STOP;
`endif
         end
`ifdef MCPU_UART_TX_PARITY_EN
         S_PARITY: if (bit_end) state_d = S_STOP;
`endif
         S_STOP: if (bit_end) begin
            // chain straight into the next start bit when more data is queued
            if (start_ok) begin
               pop      = 1'b1;
               state_d  = S_START;
               shift_d  = head;
`ifdef MCPU_UART_TX_PARITY_EN
               parity_d = ^head;
`endif
            end else begin
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Serial line value for the current state, registered one cycle later
   always_comb begin
      txd_d = 1'b1;
      case (state_q)
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shift_q[0];
`ifdef MCPU_UART_TX_PARITY_EN
         S_PARITY: txd_d = parity_q;
`endif
         default:  txd_d = 1'b1;
      endcase
   end

   // FIFO occupancy, enable and sticky overrun next-state
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      enable_d  = ctrl_wr ? data_bus[0] : enable_q;
      overrun_d = overrun_q;
      if (status_rd) overrun_d = 1'b0;
      if (push_req && !push_ok) overrun_d = 1'b1;
   end

   // STATUS word, count field saturates at 15
   always_comb begin
      cnt32       = 32'(count_q);
      status_w    = '0;
      status_w[0] = (count_q == DEPTH_C);
      status_w[1] = !fifo_nempty;
      status_w[2] = frame_active;
      status_w[3] = overrun_q;
      status_w[7:4] = (cnt32 > 32'd15) ? 4'hF : cnt32[3:0];
   end

   assign data_bus = status_rd ? status_w : 'z;

   // Control and transmit state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         txd_q     <= 1'b1;
         active_q  <= 1'b0;
         enable_q  <= 1'b1;
         overrun_q <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
`ifdef MCPU_UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
         active_q  <= (state_q != S_IDLE);
         enable_q  <= enable_d;
         overrun_q <= overrun_d;
         count_q   <= count_d;
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop)     rptr_q <= rptr_q + 1'b1;
`ifdef MCPU_UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   // FIFO storage; contents are don't-care while the entry is not counted
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= data_bus[7:0];
   end

endmodule

// File: tb/tb_mcpu_uart_tx.sv
// Bench for mcpu_uart_tx: scoreboard of pushed bytes checked by a serial
// receiver model, plus per-scenario timing and STATUS checks.
module tb_mcpu_uart_tx;
   localparam int DW  = 16;
   localparam int CPB = 4;
`ifdef MCPU_UART_TX_PARITY_EN
   localparam int FB  = 11;
`else
   localparam int FB  = 10;
`endif
   localparam int FRAME = FB * CPB;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    io_addr = 2'd0;
   logic          io_we = 1'b0;
   logic          io_re = 1'b0;
   wire  [DW-1:0] data_bus;
   logic          txd, tx_busy;
   logic          tb_drv = 1'b0;
   logic [DW-1:0] tb_dout = '0;
   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc = 0;
   logic [7:0]    sb[$];
   int            starts[$];
   bit            mon_en = 1'b1;

   assign data_bus = tb_drv ? tb_dout : 'z;

   mcpu_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .io_addr(io_addr), .io_we(io_we), .io_re(io_re),
      .data_bus(data_bus), .txd(txd), .tx_busy(tx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [FB-1:0] frame_bits(input logic [7:0] d);
      logic [FB-1:0] f;
      f = '1;
      f[0] = 1'b0;
      f[8:1] = d;
`ifdef MCPU_UART_TX_PARITY_EN
      f[9] = ^d;
`endif
      return f;
   endfunction

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d, output int at);
      @(negedge clk);
      io_addr = a; io_we = 1'b1; tb_drv = 1'b1; tb_dout = {8'h00, d};
      @(posedge clk);
      #1;
      at = cyc; io_we = 1'b0; tb_drv = 1'b0;
   endtask

   task automatic push(input logic [7:0] d, input bit accept, output int at);
      if (accept) sb.push_back(d);
      bus_write(2'd0, d, at);
   endtask

   task automatic read_status(output logic [15:0] v);
      @(negedge clk);
      io_addr = 2'd1; io_re = 1'b1;
      #1 v = data_bus;
      @(posedge clk);
      #1 io_re = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || tx_busy !== 1'b0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (sb.size() != 0 || tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_drain: queue=%0d busy=%b after %0d cycles, required queue=0 busy=0",
                  name, sb.size(), tx_busy, budget);
         sb.delete();
      end
   endtask

   // Serial receiver: samples mid-bit and checks each frame against the scoreboard
   initial begin : rx_mon
      logic [7:0] b, e;
      logic sbit, pbit, ebit, abort;
      int idx;
      forever begin
         @(negedge clk);
         if (mon_en && reset && txd === 1'b0) begin
            starts.push_back(cyc);
            b = '0; sbit = 1'b1; pbit = 1'b0; ebit = 1'b0; abort = 1'b0;
            for (int k = 0; k <= (FB - 1) * CPB + 2; k++) begin
               if (k > 0) @(negedge clk);
               if (!reset || !mon_en) begin abort = 1'b1; break; end
               if (k % CPB == 2) begin
                  idx = k / CPB;
                  if (idx == 0)           sbit = txd;
                  else if (idx <= 8)      b[idx-1] = txd;
                  else if (idx == FB - 1) ebit = txd;
                  else                    pbit = txd;
               end
            end
            if (!abort) begin
               n_tests++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL rx_frame: got unexpected byte %02h, required no frame", b);
               end else begin
                  e = sb.pop_front();
                  if (b !== e || sbit !== 1'b0 || ebit !== 1'b1) begin
                     n_fail++;
                     $display("FAIL rx_frame: got data=%02h start=%b stop=%b, required data=%02h start=0 stop=1",
                              b, sbit, ebit, e);
                  end
`ifdef MCPU_UART_TX_PARITY_EN
                  n_tests++;
                  if (pbit !== ^e) begin
                     n_fail++;
                     $display("FAIL rx_parity: byte %02h got %b, required %b", e, pbit, ^e);
                  end
`endif
               end
            end
         end
      end
   end

   task automatic test_reset();
      logic [15:0] v;
      #3 reset = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b, required 1", txd); end
      n_tests++;
      if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", tx_busy); end
      reset = 1'b1;
      read_status(v);
      n_tests++;
      if (v !== 16'h0002) begin n_fail++; $display("FAIL reset_status: got %04h, required 0002", v); end
   endtask

   task automatic test_single();
      int p, rel, fall, bad;
      logic [FB-1:0] fr;
      logic expb;
      fr = frame_bits(8'h55);
      push(8'h55, 1'b1, p);
      n_tests++;
      if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise: got %b, required 1", tx_busy); end
      bad = 0; fall = -1;
      for (int i = 0; i < FRAME + 4; i++) begin
         @(negedge clk);
         rel = cyc - p;
         expb = (rel >= 2 && rel < 2 + FRAME) ? fr[(rel - 2) / CPB] : 1'b1;
         if (txd !== expb) bad++;
         if (fall < 0 && tx_busy === 1'b0) fall = rel;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL single_waveform: got %0d wrong txd cycles, required 0", bad); end
      n_tests++;
      if (fall != 2 + FRAME) begin n_fail++; $display("FAIL single_busy_fall: got cycle %0d, required %0d", fall, 2 + FRAME); end
      wait_idle(20, "single");
   endtask

   task automatic test_overrun();
      int p;
      logic [15:0] v;
      for (int i = 1; i <= 9; i++) push(8'(i), 1'b1, p);
      push(8'h0A, 1'b0, p);
      read_status(v);
      n_tests++;
      if (v !== 16'h008D) begin n_fail++; $display("FAIL overrun_status1: got %04h, required 008D", v); end
      read_status(v);
      n_tests++;
      if (v !== 16'h0085) begin n_fail++; $display("FAIL overrun_status2: got %04h, required 0085", v); end
      wait_idle(9 * FRAME + 50, "overrun");
   endtask

   task automatic test_back_to_back();
      int p0, p1, lat, gap;
      starts.delete();
      push(8'hA3, 1'b1, p0);
      push(8'h3C, 1'b1, p1);
      wait_idle(2 * FRAME + 20, "b2b");
      lat = (starts.size() >= 1) ? starts[0] - p0 : -1;
      gap = (starts.size() >= 2) ? starts[1] - starts[0] : -1;
      n_tests++;
      if (lat != 2) begin n_fail++; $display("FAIL b2b_latency: got %0d, required 2", lat); end
      n_tests++;
      if (gap != FRAME) begin n_fail++; $display("FAIL b2b_gap: got %0d, required %0d", gap, FRAME); end
   endtask

   task automatic test_reset_mid();
      int p, q, bad;
      logic [15:0] v;
      mon_en = 1'b0;
      push(8'h5A, 1'b0, p);
      push(8'h11, 1'b0, q);
      while (cyc < p + 16) @(negedge clk);
      n_tests++;
      if (txd !== 1'b0) begin n_fail++; $display("FAIL midreset_pre_txd: got %b, required 0", txd); end
      reset = 1'b0;
      #1;
      n_tests++;
      if (txd !== 1'b1) begin n_fail++; $display("FAIL midreset_txd: got %b, required 1", txd); end
      n_tests++;
      if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b, required 0", tx_busy); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      read_status(v);
      n_tests++;
      if (v !== 16'h0002) begin n_fail++; $display("FAIL midreset_status: got %04h, required 0002", v); end
      bad = 0;
      repeat (12) begin @(negedge clk); if (txd !== 1'b1) bad++; end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL midreset_discard: got %0d low cycles, required 0", bad); end
      mon_en = 1'b1;
   endtask

   task automatic test_enable();
      int p, c, bad, lat;
      logic [15:0] v;
      starts.delete();
      bus_write(2'd2, 8'h00, c);
      push(8'h7E, 1'b1, p);
      bad = 0;
      repeat (12) begin @(negedge clk); if (txd !== 1'b1) bad++; end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL enable_hold: got %0d low cycles, required 0", bad); end
      read_status(v);
      n_tests++;
      if (v !== 16'h0010) begin n_fail++; $display("FAIL enable_status: got %04h, required 0010", v); end
      bus_write(2'd2, 8'h01, c);
      wait_idle(FRAME + 20, "enable");
      lat = (starts.size() >= 1) ? starts[0] - c : -1;
      n_tests++;
      if (lat != 2) begin n_fail++; $display("FAIL enable_latency: got %0d, required 2", lat); end
   endtask

   task automatic test_disable_mid();
      int p, c;
      starts.delete();
      push(8'h81, 1'b1, p);
      push(8'h42, 1'b1, p);
      bus_write(2'd2, 8'h00, c);
      repeat (FRAME + 10) @(negedge clk);
      n_tests++;
      if (starts.size() != 1) begin n_fail++; $display("FAIL disable_frames: got %0d frames, required 1", starts.size()); end
      n_tests++;
      if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL disable_busy: got %b, required 1", tx_busy); end
      bus_write(2'd2, 8'h01, c);
      wait_idle(FRAME + 20, "disable");
   endtask

`ifdef MCPU_UART_TX_PARITY_EN
   task automatic test_parity();
      int p, gap;
      starts.delete();
      push(8'h07, 1'b1, p);
      push(8'h03, 1'b1, p);
      wait_idle(2 * FRAME + 20, "parity");
      gap = (starts.size() >= 2) ? starts[1] - starts[0] : -1;
      n_tests++;
      if (gap != 44) begin n_fail++; $display("FAIL parity_frame_len: got %0d, required 44", gap); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_enable();
      test_disable_mid();
`ifdef MCPU_UART_TX_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end
endmodule
